// File: rtl/counter_two_speed_pkg.sv
// -----------------------------------------------------------------------------
// counter_two_speed_pkg
//
// Purpose : Shared constants and types for the two-digit BCD counter.
//           - BCD digit width and the largest legal digit value.
//           - Packed two-digit BCD struct laid out as {tens, units}, so it maps
//             directly onto the 8-bit display bus (tens in [7:4]).
// Ports   : none (package).
// -----------------------------------------------------------------------------
package counter_two_speed_pkg;

   localparam int               BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   // Field order matters: tens is declared first so it lands in the upper
   // nibble when the struct is viewed as an 8-bit vector.
   typedef struct packed {
      bcd_digit_t tens;
      bcd_digit_t units;
   } bcd2_t;

endpackage : counter_two_speed_pkg

// File: rtl/counter_two_speed_if.sv
// -----------------------------------------------------------------------------
// counter_two_speed_if
//
// Purpose : Groups the control inputs and the display output of the counter.
// Signals : SS    start/stop, synchronous to clk; each rise toggles run state
//           MODE  speed select: 0 = slow divisor, 1 = fast divisor
//           out   BCD count, [7:4] tens digit, [3:0] units digit
// Modports: master - drives SS/MODE, observes out (testbench / upstream logic)
//           slave  - the counter itself
// -----------------------------------------------------------------------------
interface counter_two_speed_if;

   logic       SS;
   logic       MODE;
   logic [7:0] out;

   modport master (
      output SS,
      output MODE,
      input  out
   );

   modport slave (
      input  SS,
      input  MODE,
      output out
   );

endinterface : counter_two_speed_if

// File: rtl/counter_two_speed_bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
//
// Purpose : One decimal digit (0..9) of a chained BCD counter. The digit
//           advances when both en and carry_in are high and wraps 9 -> 0,
//           asserting carry_out in that same cycle so the next digit up
//           advances on the same edge.
// Ports   : clk        system clock, rising edge
//           reset      synchronous, active-high; clears the digit to 0
//           en         count enable (the shared prescaler tick)
//           carry_in   carry from the next-lower digit (tie high for units)
//           digit      current digit value, always 0..9
//           carry_out  high when this digit is about to wrap 9 -> 0
// -----------------------------------------------------------------------------
module bcd_digit_counter
   import counter_two_speed_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       carry_in,
   output bcd_digit_t digit,
   output logic       carry_out
);

   logic advance;

   assign advance   = en && carry_in;
   // Combinational so the upper digit sees the carry in the same cycle and
   // both digits update on one edge (e.g. 09 -> 10 in a single step).
   assign carry_out = advance && (digit == BCD_MAX);

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         digit <= '0;
      end else if (advance) begin
         if (digit == BCD_MAX) begin
            digit <= '0;
         end else begin
            digit <= digit + BCD_W'(1);
         end
      end
   end

endmodule : bcd_digit_counter

// File: rtl/counter_two_speed.sv
// -----------------------------------------------------------------------------
// counter_two_speed
//
// Purpose : Two-digit BCD up-counter (00..99, wrapping) with a start/stop
//           toggle and two selectable count rates. A free-running prescaler
//           (advancing only while running) produces the count tick; MODE
//           picks the slow or fast divisor each cycle. Each rising edge on SS
//           toggles the run state.
// Params  : DIV_SLOW  clock cycles per count when MODE=0 (>= DIV_FAST)
//           DIV_FAST  clock cycles per count when MODE=1 (>= 1)
// Ports   : clk       system clock, rising edge
//           reset     synchronous, active-high; clears count, run, prescaler
//                     and the SS edge-detect register
//           bus       counter_two_speed_if.slave: SS, MODE in; out (8-bit BCD)
// -----------------------------------------------------------------------------
module counter_two_speed
   import counter_two_speed_pkg::*;
#(
   parameter int DIV_SLOW = 50000000,
   parameter int DIV_FAST = 5000000
)
(
   input  logic                clk,
   input  logic                reset,
   counter_two_speed_if.slave  bus
);

   // Prescaler never exceeds DIV_SLOW-1, so $clog2(DIV_SLOW) bits suffice;
   // a degenerate DIV_SLOW of 1 still needs one bit to exist.
   localparam int PW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;

   localparam logic [PW-1:0] SLOW_M1 = PW'(DIV_SLOW - 1);
   localparam logic [PW-1:0] FAST_M1 = PW'(DIV_FAST - 1);

   logic [PW-1:0] prescaler;
   logic [PW-1:0] div_m1;
   logic          run;
   logic          ss_q;
   logic          ss_rise;
   logic          tick;

   bcd_digit_t    units_d;
   bcd_digit_t    tens_d;
   logic          units_carry;
   logic          tens_carry;
   bcd2_t         count;

   // ---------------------------------------------------------------------------
   // Divisor selection and tick generation
   // ---------------------------------------------------------------------------
   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      div_m1 = SLOW_M1;
      if (bus.MODE) begin
         div_m1 = FAST_M1;
      end
   end

   // ">=" rather than "==": after a slow->fast switch the prescaler may
   // already sit above DIV_FAST-1, and the tick must then fire on the very
   // next edge instead of waiting for the prescaler to wrap around.
   assign tick    = run && (prescaler >= div_m1);
   assign ss_rise = bus.SS && !ss_q;

   // ---------------------------------------------------------------------------
   // Run state, SS edge detect and prescaler
   // ---------------------------------------------------------------------------
   // The prescaler step uses the pre-edge run value, so a rise on SS that
   // coincides with a tick still lets that tick land before counting halts.
   // Stopping only freezes the prescaler; the partial count is kept so that
   // resuming finishes the interrupted period.
   always_ff @(posedge clk) begin
      if (reset) begin
         ss_q      <= 1'b0;
         run       <= 1'b0;
         prescaler <= '0;
      end else begin
         ss_q <= bus.SS;

         if (ss_rise) begin
            run <= !run;
         end

         if (run) begin
            if (prescaler >= div_m1) begin
               prescaler <= '0;
            end else begin
               prescaler <= prescaler + PW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Two chained BCD digits: units advance on every tick, tens on the units
   // carry. Tens wrapping 9 -> 0 with a carry gives the 99 -> 00 rollover.
   // ---------------------------------------------------------------------------
   bcd_digit_counter u_units (
      .clk       (clk),
      .reset     (reset),
      .en        (tick),
      .carry_in  (1'b1),
      .digit     (units_d),
      .carry_out (units_carry)
   );

   bcd_digit_counter u_tens (
      .clk       (clk),
      .reset     (reset),
      .en        (tick),
      .carry_in  (units_carry),
      .digit     (tens_d),
      .carry_out (tens_carry)
   );

   assign count   = '{tens: tens_d, units: units_d};
   assign bus.out = count;

   // ---------------------------------------------------------------------------
   // Embedded properties: the display never shows a non-BCD nibble, and the
   // tens carry only ever means a rollover to 00.
   // ---------------------------------------------------------------------------
   a_units_bcd : assert property (@(posedge clk) disable iff (reset)
      count.units <= BCD_MAX);

   a_tens_bcd : assert property (@(posedge clk) disable iff (reset)
      count.tens <= BCD_MAX);

   a_wrap_to_zero : assert property (@(posedge clk) disable iff (reset)
      tens_carry |=> (count == '0));

endmodule : counter_two_speed

// File: tb/tb_counter_two_speed.sv
// -----------------------------------------------------------------------------
// tb_counter_two_speed
//
// Bench for counter_two_speed with DIV_SLOW=10, DIV_FAST=2. A driver applies
// one input vector per clock and advances a reference model (an integer count
// 0..99, a run flag and a count of cycles spent running since the last
// increment), pushing the expected display value for that edge into a queue.
// A monitor pops one entry after every rising edge and compares it with out.
// Directed phases walk through reset, slow/fast counting, wrap, stop/resume,
// a slow->fast switch and reset mid-count; a random phase follows.
// -----------------------------------------------------------------------------
module tb_counter_two_speed;

   localparam int DIV_SLOW = 10;
   localparam int DIV_FAST = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   counter_two_speed_if bus ();

   counter_two_speed #(
      .DIV_SLOW (DIV_SLOW),
      .DIV_FAST (DIV_FAST)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];

   // Reference model state
   int m_count   = 0;
   int m_elapsed = 0;
   bit m_run     = 1'b0;
   bit m_ss_prev = 1'b0;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: out=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // Apply one input vector for the coming rising edge and record what the
   // display must read after that edge.
   task automatic step(input bit ss, input bit mode, input bit rst);
      int div;
      @(negedge clk);
      bus.SS   = ss;
      bus.MODE = mode;
      reset    = rst;
      if (rst) begin
         m_count   = 0;
         m_elapsed = 0;
         m_run     = 1'b0;
         m_ss_prev = 1'b0;
      end else begin
         div = mode ? DIV_FAST : DIV_SLOW;
         if (m_run) begin
            m_elapsed++;
            if (m_elapsed >= div) begin
               m_elapsed = 0;
               m_count   = (m_count + 1) % 100;
            end
         end
         if (ss && !m_ss_prev) begin
            m_run = !m_run;
         end
         m_ss_prev = ss;
      end
      exp_q.push_back(to_bcd(m_count));
   endtask

   task automatic run_cycles(input int n, input bit mode);
      repeat (n) step(1'b0, mode, 1'b0);
   endtask

   // Direct check against a hand-derived constant, just after the edge of
   // the most recent step.
   task automatic expect_now(input string name, input logic [7:0] exp);
      @(posedge clk);
      #2;
      check(name, bus.out, exp);
   endtask

   // Scoreboard monitor
   always begin : monitor
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("scoreboard", bus.out, e);
      end
   end

   // Watchdog
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, out=%h", bus.out);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ss_lvl;
      bit mode_lvl;
      bus.SS   = 1'b0;
      bus.MODE = 1'b0;
      reset    = 1'b1;

      // Reset and idle
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      expect_now("reset_value", 8'h00);
      run_cycles(30, 1'b0);
      expect_now("idle_hold", 8'h00);

      // Slow counting: rise at edge k, increments at k+10 and k+20
      step(1'b1, 1'b0, 1'b0);
      run_cycles(9, 1'b0);
      expect_now("slow_before_tick", 8'h00);
      run_cycles(1, 1'b0);
      expect_now("slow_first_tick", 8'h01);
      run_cycles(10, 1'b0);
      expect_now("slow_second_tick", 8'h02);

      // SS held high for 5 cycles: exactly one toggle (stop)
      repeat (5) step(1'b1, 1'b0, 1'b0);
      run_cycles(20, 1'b0);
      expect_now("held_level_stop", 8'h02);

      // Fast counting from 00 through 99 and the wrap
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      run_cycles(198, 1'b1);
      expect_now("fast_reach_99", 8'h99);
      run_cycles(2, 1'b1);
      expect_now("fast_wrap_00", 8'h00);

      // Stop mid-period, hold, resume with preserved prescaler
      run_cycles(5, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      run_cycles(10, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      run_cycles(10, 1'b1);

      // Slow -> fast switch with prescaler at 7
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      run_cycles(7, 1'b0);
      expect_now("pre_switch", 8'h00);
      step(1'b0, 1'b1, 1'b0);
      expect_now("switch_tick", 8'h01);
      step(1'b0, 1'b1, 1'b0);
      expect_now("switch_gap", 8'h01);
      step(1'b0, 1'b1, 1'b0);
      expect_now("switch_next", 8'h02);

      // Reset while running at 47
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      run_cycles(94, 1'b1);
      expect_now("reach_47", 8'h47);
      step(1'b0, 1'b1, 1'b1);
      expect_now("reset_mid_count", 8'h00);
      run_cycles(20, 1'b1);
      expect_now("halted_after_reset", 8'h00);

      // Random phase
      ss_lvl   = 1'b0;
      mode_lvl = 1'b1;
      repeat (900) begin
         if ($urandom_range(0, 7) == 0) ss_lvl = !ss_lvl;
         if ($urandom_range(0, 39) == 0) mode_lvl = !mode_lvl;
         step(ss_lvl, mode_lvl, ($urandom_range(0, 299) == 0));
      end

      // Drain the scoreboard (bounded)
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_counter_two_speed
